// File: rtl/uart_tx_ext.sv
// Buffered UART transmitter: a small TX FIFO feeding a start/data/parity/stop
// serialiser with configurable payload width, parity and stop-bit count.
module uart_tx_ext #(
    parameter int PAYLOAD_BITS = 8,
    parameter int CLK_HZ       = 50_000_000,
    parameter int BIT_RATE     = 115200,
    parameter int STOP_BITS    = 1,
    parameter int PARITY       = 0,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [PAYLOAD_BITS-1:0]       uart_tx_data,
    input  logic                          uart_tx_en,
    output logic                          uart_txd,
    output logic                          uart_tx_busy,
    output logic                          uart_tx_full,
    output logic                          uart_tx_ovf,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int CW = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int IW = 4;

    localparam logic [CW-1:0] CNT_LAST   = CW'(CYCLES_PER_BIT - 1);
    localparam logic [IW-1:0] DATA_LAST  = IW'(PAYLOAD_BITS - 1);
    localparam logic [IW-1:0] STOP_LAST  = IW'(STOP_BITS - 1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                  state, state_nxt;
    logic [CW-1:0]           bit_cnt, cnt_nxt;
    logic [IW-1:0]           bit_idx, idx_nxt;
    logic [PAYLOAD_BITS-1:0] shift_reg, shift_nxt;
    logic                    par_bit, par_nxt;
    logic                    line_bit;
    logic                    bit_done;

    logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [LW-1:0]           count;
    logic                    push, pop, fifo_empty;

    // Full comes from the registered count, so a pop in the same cycle never rescues a write.
    assign uart_tx_full = (count == LEVEL_FULL);
    assign fifo_empty   = (count == '0);
    assign push         = uart_tx_en && !uart_tx_full;
    assign fifo_level   = count;
    assign uart_tx_busy = (state != ST_IDLE) || !fifo_empty;
    assign bit_done     = (bit_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            uart_tx_ovf <= 1'b0;
        end else begin
            uart_tx_ovf <= uart_tx_en && uart_tx_full;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= uart_tx_data;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_cnt;
        idx_nxt   = bit_idx;
        shift_nxt = shift_reg;
        par_nxt   = par_bit;
        pop       = 1'b0;
        line_bit  = 1'b1;

        if (state != ST_IDLE) cnt_nxt = bit_done ? '0 : bit_cnt + 1'b1;

        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                line_bit = 1'b0;
                if (bit_done) begin
                    state_nxt = ST_DATA;
                    idx_nxt   = '0;
                end
            end
            ST_DATA: begin
                line_bit = shift_reg[0];
                if (bit_done) begin
                    shift_nxt = shift_reg >> 1;
                    if (bit_idx == DATA_LAST) begin
                        idx_nxt   = '0;
                        state_nxt = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_nxt = bit_idx + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                line_bit = par_bit;
                if (bit_done) begin
                    state_nxt = ST_STOP;
                    idx_nxt   = '0;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    if (bit_idx == STOP_LAST) begin
                        idx_nxt = '0;
                        if (!fifo_empty) begin
                            pop       = 1'b1;
                            state_nxt = ST_START;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        idx_nxt = bit_idx + 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Parity is fixed at load time so the shifting register can't disturb it.
        if (pop) begin
            shift_nxt = mem[rd_ptr];
            par_nxt   = (^mem[rd_ptr]) ^ (PARITY == 1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            par_bit   <= 1'b0;
            uart_txd  <= 1'b1;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= cnt_nxt;
            bit_idx   <= idx_nxt;
            shift_reg <= shift_nxt;
            par_bit   <= par_nxt;
            uart_txd  <= line_bit;
        end
    end

endmodule

// File: tb/tb_uart_tx_ext.sv
// Scoreboard bench for uart_tx_ext: five instances cover 8N1, 8E1, 8O1, 8N2 and 5N1
// at 10 clocks per bit; per-instance line monitors decode frames and pop expectations.
module tb_uart_tx_ext;

    localparam int NI  = 5;
    localparam int CPB = 10;
    localparam int PB_A  [NI] = '{8, 8, 8, 8, 5};
    localparam int PAR_A [NI] = '{0, 2, 1, 0, 0};
    localparam int SB_A  [NI] = '{1, 1, 1, 2, 1};

    typedef struct packed {
        logic [7:0] data;
        logic       par;
    } exp_t;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] din;
    logic       en   [NI];
    logic       txd  [NI];
    logic       busy [NI];
    logic       full [NI];
    logic       ovf  [NI];
    logic [2:0] lvl  [NI];

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t sb_q [NI][$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic expect_frame(input int idx, input logic [7:0] data, input logic par);
        exp_t e;
        e.data = data;
        e.par  = par;
        sb_q[idx].push_back(e);
    endtask

    // Caller is at a negedge; returns at the negedge after the accepting edge.
    task automatic apply_stimulus(input int idx, input logic [7:0] data);
        din     = data;
        en[idx] = 1'b1;
        @(negedge clk);
        en[idx] = 1'b0;
    endtask

    task automatic wait_idle(input int idx, input int limit, output int end_cyc);
        logic done;
        done = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (busy[idx] === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        end_cyc = cyc;
        check_output($sformatf("idle_reached_u%0d", idx), 32'(done), 32'd1);
    endtask

    task automatic wait_txd_low(input int idx, input int limit);
        logic done;
        done = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (txd[idx] === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        check_output($sformatf("start_seen_u%0d", idx), 32'(done), 32'd1);
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int PBG  = PB_A[g];
        localparam int PARG = PAR_A[g];
        localparam int SBG  = SB_A[g];
        localparam int NB   = 1 + PBG + ((PARG != 0) ? 1 : 0) + SBG;

        uart_tx_ext #(
            .PAYLOAD_BITS(PBG),
            .CLK_HZ      (1_000_000),
            .BIT_RATE    (100_000),
            .STOP_BITS   (SBG),
            .PARITY      (PARG),
            .FIFO_DEPTH  (4)
        ) u_dut (
            .clk         (clk),
            .resetn      (resetn),
            .uart_tx_data(din[PBG-1:0]),
            .uart_tx_en  (en[g]),
            .uart_txd    (txd[g]),
            .uart_tx_busy(busy[g]),
            .uart_tx_full(full[g]),
            .uart_tx_ovf (ovf[g]),
            .fifo_level  (lvl[g])
        );

        // Line monitor: every bit must hold for CPB samples; aborted frames are dropped.
        initial begin : mon
            logic [NB*CPB-1:0] smp;
            logic [NB-1:0]     bits;
            logic              aborted, stable, stop_ok, rx_par;
            logic [7:0]        rx;
            exp_t              want;
            forever begin
                @(negedge clk);
                if (resetn === 1'b1 && txd[g] === 1'b0) begin
                    smp     = '0;
                    smp[0]  = txd[g];
                    aborted = 1'b0;
                    for (int k = 1; k < NB * CPB; k++) begin
                        @(negedge clk);
                        if (resetn !== 1'b1) begin
                            aborted = 1'b1;
                            break;
                        end
                        smp[k] = txd[g];
                    end
                    if (!aborted) begin
                        stable = 1'b1;
                        bits   = '0;
                        for (int j = 0; j < NB; j++) begin
                            bits[j] = smp[j*CPB];
                            for (int c = 1; c < CPB; c++)
                                if (smp[j*CPB+c] !== smp[j*CPB]) stable = 1'b0;
                        end
                        rx = '0;
                        for (int i = 0; i < PBG; i++) rx[i] = bits[1+i];
                        rx_par  = (PARG != 0) ? bits[1+PBG] : 1'b0;
                        stop_ok = 1'b1;
                        for (int s = 0; s < SBG; s++)
                            if (bits[NB-SBG+s] !== 1'b1) stop_ok = 1'b0;
                        check_output($sformatf("frame_expected_u%0d", g), 32'(sb_q[g].size() != 0), 32'd1);
                        if (sb_q[g].size() != 0) begin
                            want = sb_q[g].pop_front();
                            check_output($sformatf("frame_u%0d", g),
                                         32'({stable, stop_ok, rx_par, rx}),
                                         32'({1'b1, 1'b1, want.par, want.data}));
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin : stim
        int c0;
        int c1;
        resetn = 1'b1;
        din    = 8'h00;
        for (int i = 0; i < NI; i++) en[i] = 1'b0;

        // Asynchronous reset before any clock edge, with a write strobe that must be ignored.
        #1 resetn = 1'b0;
        #1;
        for (int i = 0; i < NI; i++)
            check_output($sformatf("reset_state_u%0d", i),
                         32'({txd[i], busy[i], full[i], ovf[i], lvl[i]}), 32'h40);
        din   = 8'h5A;
        en[0] = 1'b1;
        repeat (3) @(negedge clk);
        check_output("reset_ignores_en", 32'(lvl[0]), 32'd0);
        resetn = 1'b1;
        en[0]  = 1'b0;
        @(negedge clk);
        check_output("post_reset_idle", 32'({busy[0], lvl[0]}), 32'd0);

        // 8N1 0xA5: start edge two clocks after the accepting edge, busy drops 101 edges later.
        expect_frame(0, 8'hA5, 1'b0);
        apply_stimulus(0, 8'hA5);
        c0 = cyc;
        check_output("accept_u0", 32'({txd[0], busy[0], lvl[0]}), 32'({1'b1, 1'b1, 3'd1}));
        @(negedge clk);
        check_output("pop_u0", 32'({txd[0], lvl[0]}), 32'({1'b1, 3'd0}));
        @(negedge clk);
        check_output("start_latency_u0", 32'(txd[0]), 32'd0);
        wait_idle(0, 200, c1);
        check_output("frame_len_u0", 32'(c1 - c0), 32'd101);
        check_output("line_idle_u0", 32'(txd[0]), 32'd1);

        // Even parity: 0x07 -> 1, 0x80 -> 1.
        expect_frame(1, 8'h07, 1'b1);
        expect_frame(1, 8'h80, 1'b1);
        apply_stimulus(1, 8'h07);
        apply_stimulus(1, 8'h80);
        wait_idle(1, 400, c1);

        // Odd parity: 0x07 -> 0, 0x03 -> 1.
        expect_frame(2, 8'h07, 1'b0);
        expect_frame(2, 8'h03, 1'b1);
        apply_stimulus(2, 8'h07);
        apply_stimulus(2, 8'h03);
        wait_idle(2, 400, c1);

        // 8N2 burst: the first entry pops while the second is written, so the level peaks at 2.
        expect_frame(3, 8'h55, 1'b0);
        expect_frame(3, 8'h00, 1'b0);
        expect_frame(3, 8'hFF, 1'b0);
        apply_stimulus(3, 8'h55);
        apply_stimulus(3, 8'h00);
        apply_stimulus(3, 8'hFF);
        c0 = cyc;
        check_output("burst_level_u3", 32'({txd[3], lvl[3]}), 32'({1'b0, 3'd2}));
        repeat (160) @(negedge clk);
        check_output("second_pop_u3", 32'(lvl[3]), 32'd1);
        wait_idle(3, 400, c1);
        check_output("contiguous_u3", 32'(c1 - c0), 32'd329);
        check_output("drained_u3", 32'(lvl[3]), 32'd0);

        // 5-bit payload.
        expect_frame(4, 8'h1F, 1'b0);
        apply_stimulus(4, 8'h1F);
        wait_idle(4, 200, c1);

        // Six consecutive writes into a depth-4 FIFO: five accepted, the sixth rejected.
        for (int k = 0; k < 6; k++) begin
            din   = 8'(8'h11 * (k + 1));
            en[0] = 1'b1;
            if (k < 5) expect_frame(0, 8'(8'h11 * (k + 1)), 1'b0);
            @(negedge clk);
            if (k == 4)
                check_output("full_no_ovf_u0", 32'({full[0], ovf[0]}), 32'({1'b1, 1'b0}));
        end
        en[0] = 1'b0;
        check_output("ovf_pulse_u0", 32'({ovf[0], full[0], lvl[0]}), 32'({1'b1, 1'b1, 3'd4}));
        @(negedge clk);
        check_output("ovf_single_u0", 32'(ovf[0]), 32'd0);
        wait_idle(0, 700, c1);
        check_output("fifo_empty_u0", 32'({full[0], lvl[0]}), 32'd0);

        // Reset mid-DATA abandons the frame; the next byte goes out cleanly.
        expect_frame(0, 8'h3C, 1'b0);
        apply_stimulus(0, 8'h3C);
        wait_txd_low(0, 20);
        repeat (35) @(negedge clk);
        @(posedge clk);
        #2 resetn = 1'b0;
        sb_q[0].delete();
        #1;
        check_output("async_abort_u0", 32'({txd[0], busy[0], lvl[0]}), 32'({1'b1, 1'b0, 3'd0}));
        din   = 8'h99;
        en[0] = 1'b1;
        repeat (2) @(negedge clk);
        check_output("abort_en_ignored_u0", 32'(lvl[0]), 32'd0);
        resetn = 1'b1;
        en[0]  = 1'b0;
        @(negedge clk);
        expect_frame(0, 8'hC3, 1'b0);
        apply_stimulus(0, 8'hC3);
        c0 = cyc;
        wait_idle(0, 200, c1);
        check_output("resume_len_u0", 32'(c1 - c0), 32'd101);

        repeat (5) @(negedge clk);
        for (int i = 0; i < NI; i++)
            check_output($sformatf("sb_drained_u%0d", i), 32'(sb_q[i].size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
